alu_input_sequencer: RTL and testbench

//  Front-end controller for the board-level ALU. Debounces the four push buttons, turns them into

---
 rtl/alu_input_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_alu_input_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_input_sequencer.sv
// Board front-end for the ALU: debounces four push buttons into single-cycle pulses and
// sequences operand A, operand B and opcode loads from the shared switches, then launches the ALU.
module alu_input_sequencer #(
   parameter int NB_OPERANDO     = 8,
   parameter int NB_OPCODE       = 6,
   parameter int NB_OUT          = NB_OPERANDO,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [NB_OPERANDO-1:0] i_switch,
   input  logic                   i_boton_1,
   input  logic                   i_boton_2,
   input  logic                   i_boton_3,
   input  logic                   i_boton_4,
   input  logic [NB_OUT-1:0]      i_alu_result,
   output logic [NB_OPERANDO-1:0] o_dato_a,
   output logic [NB_OPERANDO-1:0] o_dato_b,
   output logic [NB_OPCODE-1:0]   o_opcode,
   output logic [NB_OUT-1:0]      o_result,
   output logic                   o_valid,
   output logic                   o_error,
   output logic [2:0]             o_state
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      READY   = 3'd3,
      EXEC    = 3'd4,
      DONE    = 3'd5
   } state_t;

   logic [3:0] btn_raw;
   logic [3:0] sync1_reg;
   logic [3:0] sync2_reg;
   logic [3:0] pulse;

   assign btn_raw = {i_boton_4, i_boton_3, i_boton_2, i_boton_1};

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= btn_raw;
         sync2_reg <= sync1_reg;
      end
   end

   // Accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
         logic [CNT_W-1:0] cnt_reg;
         logic             deb_reg;
         logic             deb_q_reg;

         always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
               cnt_reg   <= '0;
               deb_reg   <= 1'b0;
               deb_q_reg <= 1'b0;
            end else begin
               deb_q_reg <= deb_reg;
               if (sync2_reg[gi] == deb_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  cnt_reg <= '0;
                  deb_reg <= ~deb_reg;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign pulse[gi] = deb_reg & ~deb_q_reg;
      end
   endgenerate

   function automatic logic op_legal(input logic [NB_OPCODE-1:0] op);
      case (op)
         NB_OPCODE'('h20), NB_OPCODE'('h22), NB_OPCODE'('h24), NB_OPCODE'('h25),
         NB_OPCODE'('h26), NB_OPCODE'('h03), NB_OPCODE'('h02), NB_OPCODE'('h27): op_legal = 1'b1;
         default: op_legal = 1'b0;
      endcase
   endfunction

   state_t                 state_reg, state_next;
   logic [NB_OPERANDO-1:0] dato_a_reg, dato_a_next;
   logic [NB_OPERANDO-1:0] dato_b_reg, dato_b_next;
   logic [NB_OPCODE-1:0]   opcode_reg, opcode_next;
   logic [NB_OUT-1:0]      result_reg, result_next;
   logic                   valid_reg, valid_next;
   logic                   error_reg, error_next;
   logic [NB_OPCODE-1:0]   op_sw;
   logic                   op_ok;

   assign op_sw = i_switch[NB_OPCODE-1:0];
   assign op_ok = op_legal(op_sw);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_reg  <= WAIT_A;
         dato_a_reg <= '0;
         dato_b_reg <= '0;
         opcode_reg <= '0;
         result_reg <= '0;
         valid_reg  <= 1'b0;
         error_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         dato_a_reg <= dato_a_next;
         dato_b_reg <= dato_b_next;
         opcode_reg <= opcode_next;
         result_reg <= result_next;
         valid_reg  <= valid_next;
         error_reg  <= error_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      dato_a_next = dato_a_reg;
      dato_b_next = dato_b_reg;
      opcode_next = opcode_reg;
      result_next = result_reg;
      valid_next  = valid_reg;
      error_next  = error_reg;
      case (state_reg)
         WAIT_A: begin
            if (pulse[0]) begin
               dato_a_next = i_switch;
               state_next  = WAIT_B;
            end
         end
         WAIT_B: begin
            if (pulse[1]) begin
               dato_b_next = i_switch;
               state_next  = WAIT_OP;
            end
         end
         WAIT_OP, READY: begin
            if (state_reg == READY && pulse[3]) begin
               state_next = EXEC;
            end else if (pulse[2]) begin
               if (op_ok) begin
                  opcode_next = op_sw;
                  error_next  = 1'b0;
                  state_next  = READY;
               end else begin
                  error_next = 1'b1;
               end
            end
         end
         EXEC: begin
            result_next = i_alu_result;
            valid_next  = 1'b1;
            state_next  = DONE;
         end
         DONE: begin
            if (pulse[0]) begin
               dato_a_next = i_switch;
               valid_next  = 1'b0;
               state_next  = WAIT_B;
            end else if (pulse[2]) begin
               if (op_ok) begin
                  opcode_next = op_sw;
                  error_next  = 1'b0;
                  valid_next  = 1'b0;
                  state_next  = READY;
               end else begin
                  error_next = 1'b1;
               end
            end else if (pulse[3]) begin
               state_next = EXEC;
            end
         end
         default: state_next = WAIT_A;
      endcase
   end

   assign o_dato_a = dato_a_reg;
   assign o_dato_b = dato_b_reg;
   assign o_opcode = opcode_reg;
   assign o_result = result_reg;
   assign o_valid  = valid_reg;
   assign o_error  = error_reg;
   assign o_state  = state_reg;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer: button debounce timing, load/exec sequencing,
// opcode legality, pulse filtering per state and asynchronous reset.
module tb_alu_input_sequencer;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b0;
   logic [7:0] i_switch = '0;
   logic       i_boton_1 = 1'b0;
   logic       i_boton_2 = 1'b0;
   logic       i_boton_3 = 1'b0;
   logic       i_boton_4 = 1'b0;
   logic [7:0] i_alu_result;
   logic [7:0] o_dato_a;
   logic [7:0] o_dato_b;
   logic [5:0] o_opcode;
   logic [7:0] o_result;
   logic       o_valid;
   logic       o_error;
   logic [2:0] o_state;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 i_clk = ~i_clk;

   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
      case (op)
         6'h20:   alu_ref = a + b;
         6'h22:   alu_ref = a - b;
         6'h24:   alu_ref = a & b;
         6'h25:   alu_ref = a | b;
         6'h26:   alu_ref = a ^ b;
         6'h03:   alu_ref = 8'($signed(a) >>> b);
         6'h02:   alu_ref = a >> b;
         6'h27:   alu_ref = ~(a | b);
         default: alu_ref = 8'h00;
      endcase
   endfunction

   assign i_alu_result = alu_ref(o_dato_a, o_dato_b, o_opcode);

   alu_input_sequencer #(
      .NB_OPERANDO(8), .NB_OPCODE(6), .NB_OUT(8), .DEBOUNCE_CYCLES(4)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_switch(i_switch),
      .i_boton_1(i_boton_1), .i_boton_2(i_boton_2), .i_boton_3(i_boton_3), .i_boton_4(i_boton_4),
      .i_alu_result(i_alu_result),
      .o_dato_a(o_dato_a), .o_dato_b(o_dato_b), .o_opcode(o_opcode), .o_result(o_result),
      .o_valid(o_valid), .o_error(o_error), .o_state(o_state)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_assert++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [5:0] op, input logic [7:0] res, input logic v,
                          input logic e, input logic [2:0] st);
      chk({tag, ".dato_a"}, 32'(o_dato_a), 32'(a));
      chk({tag, ".dato_b"}, 32'(o_dato_b), 32'(b));
      chk({tag, ".opcode"}, 32'(o_opcode), 32'(op));
      chk({tag, ".result"}, 32'(o_result), 32'(res));
      chk({tag, ".valid"},  32'(o_valid),  32'(v));
      chk({tag, ".error"},  32'(o_error),  32'(e));
      chk({tag, ".state"},  32'(o_state),  32'(st));
      $display("step %-12s a=%h b=%h op=%h res=%h v=%b e=%b st=%0d",
               tag, o_dato_a, o_dato_b, o_opcode, o_result, o_valid, o_error, o_state);
   endtask

   // Drive a clean press (10 cycles high) on a set of buttons, then wait out the release debounce.
   task automatic press(input logic [3:0] btns, input logic [7:0] sw);
      i_switch = sw;
      {i_boton_4, i_boton_3, i_boton_2, i_boton_1} = btns;
      tick(10);
      {i_boton_4, i_boton_3, i_boton_2, i_boton_1} = 4'b0000;
      tick(8);
   endtask

   initial begin
      tick(2);
      chk_all("reset", 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 3'd0);
      i_reset = 1'b1;
      tick(1);

      // Buttons 2..4 are ignored in WAIT_A
      press(4'b0010, 8'h55);
      press(4'b0100, 8'h55);
      press(4'b1000, 8'h55);
      chk_all("waita_ign", 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 3'd0);

      // Short press filtered
      i_switch  = 8'hC0;
      i_boton_1 = 1'b1;
      tick(3);
      i_boton_1 = 1'b0;
      tick(8);
      chk_all("glitch3", 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 3'd0);

      // Exact latency: first sample at edge k, FSM acts at edge k+6
      i_boton_1 = 1'b1;
      tick(6);
      chk("lat_k5.state", 32'(o_state), 32'd0);
      tick(1);
      chk("lat_k6.state", 32'(o_state), 32'd1);
      chk("lat_k6.dato_a", 32'(o_dato_a), 32'hC0);
      tick(3);
      i_boton_1 = 1'b0;
      tick(10);
      chk_all("held_once", 8'hC0, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 3'd1);

      press(4'b0010, 8'h01);
      chk_all("load_b", 8'hC0, 8'h01, 6'h00, 8'h00, 1'b0, 1'b0, 3'd2);
      press(4'b0100, 8'h20);
      chk_all("load_add", 8'hC0, 8'h01, 6'h20, 8'h00, 1'b0, 1'b0, 3'd3);

      // Execute ADD with cycle-exact EXEC/DONE checks
      i_boton_4 = 1'b1;
      tick(6);
      chk("exec_k5.state", 32'(o_state), 32'd3);
      tick(1);
      chk("exec_k6.state", 32'(o_state), 32'd4);
      chk("exec_k6.valid", 32'(o_valid), 32'd0);
      tick(1);
      chk_all("add_done", 8'hC0, 8'h01, 6'h20, 8'hC1, 1'b1, 1'b0, 3'd5);
      tick(2);
      i_boton_4 = 1'b0;
      tick(10);

      // Reload SUB from DONE and re-run
      press(4'b0100, 8'h22);
      chk_all("sub_ready", 8'hC0, 8'h01, 6'h22, 8'hC1, 1'b0, 1'b0, 3'd3);
      press(4'b1000, 8'h00);
      chk_all("sub_done", 8'hC0, 8'h01, 6'h22, 8'hBF, 1'b1, 1'b0, 3'd5);

      // Illegal opcode handling in WAIT_OP
      press(4'b0001, 8'h05);
      chk_all("reload_a", 8'h05, 8'h01, 6'h22, 8'hBF, 1'b0, 1'b0, 3'd1);
      press(4'b0010, 8'h03);
      press(4'b0100, 8'h3F);
      chk_all("illegal_op", 8'h05, 8'h03, 6'h22, 8'hBF, 1'b0, 1'b1, 3'd2);
      press(4'b0100, 8'h24);
      chk_all("legal_and", 8'h05, 8'h03, 6'h24, 8'hBF, 1'b0, 1'b0, 3'd3);
      // Switch bits above the opcode field are ignored
      press(4'b0100, 8'hE5);
      chk_all("op_upper", 8'h05, 8'h03, 6'h25, 8'hBF, 1'b0, 1'b0, 3'd3);
      press(4'b1000, 8'h00);
      chk_all("or_done", 8'h05, 8'h03, 6'h25, 8'h07, 1'b1, 1'b0, 3'd5);

      // All buttons together in DONE: only A loads
      press(4'b1111, 8'h0A);
      chk_all("all4_done", 8'h0A, 8'h03, 6'h25, 8'h07, 1'b0, 1'b0, 3'd1);

      // Reset asserted in the middle of EXEC
      press(4'b0010, 8'h03);
      press(4'b0100, 8'h20);
      i_boton_4 = 1'b1;
      tick(7);
      chk("pre_rst.state", 32'(o_state), 32'd4);
      #2;
      i_reset   = 1'b0;
      i_boton_4 = 1'b0;
      #1;
      chk_all("async_rst", 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 3'd0);
      tick(2);
      i_reset = 1'b1;
      tick(2);

      // Bouncy press: 1-cycle toggles, then stable high
      i_switch = 8'h77;
      for (int i = 0; i < 6; i++) begin
         i_boton_1 = (i % 2 == 0);
         tick(1);
      end
      i_boton_1 = 1'b1;
      tick(6);
      chk("bounce_k5.state", 32'(o_state), 32'd0);
      chk("bounce_k5.dato_a", 32'(o_dato_a), 32'h00);
      tick(1);
      chk("bounce_k6.state", 32'(o_state), 32'd1);
      chk("bounce_k6.dato_a", 32'(o_dato_a), 32'h77);
      i_boton_1 = 1'b0;
      tick(10);
      chk_all("bounce_end", 8'h77, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 3'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
